cache_control_nway: RTL
=======================

Name: cache_control_nway

Overview:
- Parametrised control FSM for an N-way set-associative, write-back, write-allocate cache. Successor of the fixed 4-way controller.
- Sits between the cache datapath (tag/valid/dirty/data arrays, pseudo-LRU array, address mux) and physical memory.
- New over the 4-way controller:
  - Way count is a parameter.
  - Victim way is latched at miss time.
  - LRU is updated on every hit.
  - Synchronous reset.
  - Saturating hit/miss/writeback counters with clear.

Parameters:
- WAYS, 8, number of ways; power of two, 2..16.
- WAY_W, $clog2(WAYS), way-index width (derived, not overridden).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  CPU access request; held until cpu_resp.
- readwrite  in  1  0 = read, 1 = write.
- hit  in  WAYS  per-way tag-match-and-valid.
- valid  in  WAYS  per-way valid bits of the indexed set.
- dirty  in  WAYS  per-way dirty bits of the indexed set.
- lru_victim  in  WAY_W  pseudo-LRU victim way for the indexed set.
- pmem_resp  in  1  physical memory done.
- clr_counters  in  1  synchronous clear of all counters.
- cpu_resp  out  1  access complete.
- data_writeword  out  WAYS  word write enable (CPU write hit).
- data_writeline  out  WAYS  line write enable (fill).
- tag_write, valid_write, dirty_write  out  WAYS each  array write enables.
- valid_in, dirty_in  out  1 each  write values.
- wb_sel  out  1  1 = datapath merges CPU write data.
- lru_update  out  1  pseudo-LRU array write.
- lru_way  out  WAY_W  most-recently-used way to record.
- adr_sel  out  1  0 = CPU address, 1 = victim tag address (writeback).
- victim_way  out  WAY_W  latched victim, used by the datapath output mux.
- load_adr  out  1  load pmem address register.
- pmem_read, pmem_write  out  1 each  memory strobes.
- hit_count, miss_count, wb_count  out  CNT_W each  performance counters.

Behaviour:
- Reset: rst high at an edge gives state IDLE, victim_way 0, all counters 0, was_miss 0. All outputs are 0 while rst is high, regardless of state. An in-flight pmem transaction is abandoned; memory tolerates a strobe drop.
- States: IDLE, WRITE_BACK, WB_GAP, FILL, DONE. All strobes are combinational from state and inputs.
- IDLE, req and |hit:
  - cpu_resp=1 in the same cycle (zero-wait hit).
  - h = lowest set index of hit; more than one hit bit set is an assertion failure.
  - lru_update=1 and lru_way=h on every hit.
  - Write: data_writeword[h]=1, dirty_write[h]=1, dirty_in=1, wb_sel=1.
  - hit_count increments unless was_miss=1; was_miss clears.
- IDLE, req and no hit:
  - load_adr=1.
  - Latch v = lowest index with valid=0; if every way is valid, v = lru_victim.
  - If valid[v] and dirty[v], go to WRITE_BACK; otherwise go to FILL.
  - Decide using combinational v; victim_way holds v from the next cycle.
- IDLE, req low: stay in IDLE, no strobes.
- WRITE_BACK: pmem_write=1, adr_sel=1. On pmem_resp: wb_count increments, go to WB_GAP.
- WB_GAP: one cycle with all strobes 0; load_adr=1, adr_sel=0; go to FILL.
- FILL:
  - pmem_read=1.
  - On pmem_resp: data_writeline, tag_write, valid_write and dirty_write asserted for victim_way; valid_in=1, dirty_in=0; lru_update=1, lru_way=victim_way; go to DONE.
- DONE: miss_count increments, was_miss=1, go to IDLE. IDLE then sees the hit and completes the access; a write merges on this replay.
- Latency:
  - Read/write hit: 0 extra cycles.
  - Clean miss: F+2 cycles, where F = FILL cycles including the pmem_resp cycle.
  - Dirty miss: W+1+F+2 cycles, where W = WRITE_BACK cycles.
- req deasserted mid-miss: the sequence completes; no cpu_resp is issued unless req is high in IDLE.
- pmem_resp outside WRITE_BACK/FILL: ignored.
- Counters: saturate at all-ones. clr_counters has priority over increment in the same cycle.

Decomposition:
- Shared cache package:
  - cache_state_t enum.
  - WAYS default constant.
  - Function onehot_of(way) returning a WAYS-wide vector.
- One sub-module, cache_victim_select: combinational; inputs valid and lru_victim; outputs v and all_valid (first-invalid priority, else LRU).

Test Plan:
- Reset, then read with hit=8'b0000_0100 -> same-cycle cpu_resp=1, lru_way=2, hit_count=1, no pmem strobes.
- Write hit on way 5 -> data_writeword=8'b0010_0000, dirty_in=1, wb_sel=1, cpu_resp in 1 cycle.
- Read miss, valid=8'b1111_0111 -> victim_way=3, FILL with pmem_resp after 4 cycles, fill strobes on way 3, miss_count=1, cpu_resp on replay, hit_count unchanged.
- Read miss, all valid, lru_victim=6, dirty[6]=1 -> WRITE_BACK with adr_sel=1, WB_GAP, FILL, wb_count=1; lru_victim changing to 1 during FILL does not move victim_way.
- rst asserted mid-FILL -> next cycle IDLE with pmem_read=0, all counters 0.
- Counters at 16'hFFFF plus one more hit -> stays 16'hFFFF; clr_counters together with a hit -> 0.

Source files
------------

// File: rtl/cache_control_nway_pkg.sv
// Shared definitions for the N-way cache controller: FSM state encoding,
// way-count limits and a one-hot helper.
package cache_control_nway_pkg;

  localparam int unsigned CACHE_WAYS = 8;
  localparam int unsigned MAX_WAYS   = 16;
  localparam int unsigned WAY_IDX_W  = $clog2(MAX_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_BACK,
    WB_GAP,
    FILL,
    DONE
  } cache_state_t;

  // Callers size-cast the result down to their own way count.
  function automatic logic [MAX_WAYS-1:0] onehot_of(input logic [WAY_IDX_W-1:0] way);
    return {{(MAX_WAYS-1){1'b0}}, 1'b1} << way;
  endfunction

endpackage

// File: rtl/cache_control_nway_victim_select.sv
// Replacement-way choice for a miss: the first invalid way wins,
// otherwise the pseudo-LRU victim of a full set.
module cache_victim_select #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] lru_victim,
  output logic [WAY_W-1:0] v,
  output logic             all_valid
);

  logic found;

  always_comb begin
    v         = lru_victim;
    found     = 1'b0;
    all_valid = &valid;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!valid[i] && !found) begin
        v     = WAY_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache,
// with a miss-time latched victim and saturating performance counters.
module cache_control_nway
  import cache_control_nway_pkg::*;
#(
  parameter  int unsigned WAYS  = CACHE_WAYS,
  localparam int unsigned WAY_W = $clog2(WAYS),
  parameter  int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             readwrite,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic [WAY_W-1:0] lru_victim,
  input  logic             pmem_resp,
  input  logic             clr_counters,
  output logic             cpu_resp,
  output logic [WAYS-1:0]  data_writeword,
  output logic [WAYS-1:0]  data_writeline,
  output logic [WAYS-1:0]  tag_write,
  output logic [WAYS-1:0]  valid_write,
  output logic [WAYS-1:0]  dirty_write,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             wb_sel,
  output logic             lru_update,
  output logic [WAY_W-1:0] lru_way,
  output logic             adr_sel,
  output logic [WAY_W-1:0] victim_way,
  output logic             load_adr,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  cache_state_t     state, state_nxt;
  logic             was_miss;
  logic             any_hit, hit_found, all_valid, victim_dirty;
  logic [WAY_W-1:0] h, v;
  logic [WAYS-1:0]  oh_h, oh_v;
  logic             hit_inc, miss_inc, wb_inc, miss_start;

  cache_victim_select #(.WAYS(WAYS)) u_victim (
    .valid      (valid),
    .lru_victim (lru_victim),
    .v          (v),
    .all_valid  (all_valid)
  );

  always_comb begin
    h         = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit[i] && !hit_found) begin
        h         = WAY_W'(i);
        hit_found = 1'b1;
      end
    end
  end

  assign any_hit = |hit;
  assign oh_h    = WAYS'(onehot_of(WAY_IDX_W'(h)));
  assign oh_v    = WAYS'(onehot_of(WAY_IDX_W'(victim_way)));
  // A non-full set always yields an invalid victim, so dirtiness only matters when full.
  assign victim_dirty = all_valid & dirty[v];

  assign miss_start = (state == IDLE) && req && !any_hit;
  assign hit_inc    = (state == IDLE) && req && any_hit && !was_miss;
  assign miss_inc   = (state == DONE);
  assign wb_inc     = (state == WRITE_BACK) && pmem_resp;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && !(&cnt)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      victim_way <= '0;
      was_miss   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) victim_way <= v;
      if (state == DONE) was_miss <= 1'b1;
      else if ((state == IDLE) && req && any_hit) was_miss <= 1'b0;
      hit_count  <= bump(hit_count,  hit_inc,  clr_counters);
      miss_count <= bump(miss_count, miss_inc, clr_counters);
      wb_count   <= bump(wb_count,   wb_inc,   clr_counters);
    end
  end

  always_comb begin
    state_nxt      = state;
    cpu_resp       = 1'b0;
    data_writeword = '0;
    data_writeline = '0;
    tag_write      = '0;
    valid_write    = '0;
    dirty_write    = '0;
    valid_in       = 1'b0;
    dirty_in       = 1'b0;
    wb_sel         = 1'b0;
    lru_update     = 1'b0;
    lru_way        = '0;
    adr_sel        = 1'b0;
    load_adr       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req && any_hit) begin
            cpu_resp   = 1'b1;
            lru_update = 1'b1;
            lru_way    = h;
            if (readwrite) begin
              data_writeword = oh_h;
              dirty_write    = oh_h;
              dirty_in       = 1'b1;
              wb_sel         = 1'b1;
            end
          end else if (req) begin
            load_adr  = 1'b1;
            state_nxt = victim_dirty ? WRITE_BACK : FILL;
          end
        end
        WRITE_BACK: begin
          pmem_write = 1'b1;
          adr_sel    = 1'b1;
          if (pmem_resp) state_nxt = WB_GAP;
        end
        WB_GAP: begin
          load_adr  = 1'b1;
          state_nxt = FILL;
        end
        FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            data_writeline = oh_v;
            tag_write      = oh_v;
            valid_write    = oh_v;
            dirty_write    = oh_v;
            valid_in       = 1'b1;
            lru_update     = 1'b1;
            lru_way        = victim_way;
            state_nxt      = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && req) |-> $onehot0(hit));

endmodule
